// File: rtl/hp_damage_ctrl.sv
`timescale 1ns/1ps
// hp_damage_ctrl
// Frame-synchronous HP damage sequencer. Bullet collision levels are latched
// over a video frame and resolved into one combined damage event at
// frame_tick. A hit opens an invulnerability window of INV_FRAMES ticks, and
// reaching zero HP parks the block in DEAD until restart.
//
// Ports:
//   Pclk          in   pixel clock, all state on the rising edge
//   rst_n         in   asynchronous active-low reset
//   frame_tick    in   one-cycle pulse at the end of active video
//   isCollisionB1 in   level, player overlaps group-1 bullets on this pixel
//   isCollisionB2 in   level, player overlaps group-2 bullets on this pixel
//   restart       in   one-cycle new-game request (beats a coincident tick)
//   hp            out  current HP, 0..HP_MAX
//   bar_x_end     out  BAR_X0 + hp, right edge for the HP bar renderer
//   hit_pulse     out  one-cycle pulse when damage is applied
//   invuln        out  high during the invulnerability window
//   blink         out  sprite flash, inv_cnt[2] while invulnerable
//   dead          out  high in DEAD
module hp_damage_ctrl #(
  parameter int HP_MAX     = 150,
  parameter int DMG_B1     = 30,
  parameter int DMG_B2     = 30,
  parameter int INV_FRAMES = 60,
  parameter int BAR_X0     = 50
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       isCollisionB1,
  input  logic       isCollisionB2,
  input  logic       restart,
  output logic [7:0] hp,
  output logic [9:0] bar_x_end,
  output logic       hit_pulse,
  output logic       invuln,
  output logic       blink,
  output logic       dead
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  localparam logic [7:0] HP_MAX_8  = 8'(HP_MAX);
  localparam logic [8:0] DMG_B1_9  = 9'(DMG_B1);
  localparam logic [8:0] DMG_B2_9  = 9'(DMG_B2);
  localparam logic [7:0] INV_8     = 8'(INV_FRAMES);
  localparam logic [9:0] BAR_X0_10 = 10'(BAR_X0);

  state_t     r_state;
  logic       r_l1;
  logic       r_l2;
  logic [7:0] r_inv_cnt;

  // A collision present in the tick cycle itself still counts for the frame.
  logic       w_e1;
  logic       w_e2;
  logic [8:0] w_dmg;
  logic [7:0] w_hp_left;
  logic [7:0] w_cnt_dec;

  assign w_e1      = r_l1 | isCollisionB1;
  assign w_e2      = r_l2 | isCollisionB2;
  // 9 bits so two full-size damage values cannot wrap before the compare.
  assign w_dmg     = (w_e1 ? DMG_B1_9 : 9'd0) + (w_e2 ? DMG_B2_9 : 9'd0);
  // Only used when w_dmg < hp, so the low 8 bits hold the whole value.
  assign w_hp_left = hp - w_dmg[7:0];
  assign w_cnt_dec = r_inv_cnt - 8'd1;

  // Damage FSM: latches, HP, invulnerability counter and all registered outputs.
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ALIVE;
      r_l1      <= 1'b0;
      r_l2      <= 1'b0;
      r_inv_cnt <= 8'd0;
      hp        <= HP_MAX_8;
      bar_x_end <= BAR_X0_10 + {2'b00, HP_MAX_8};
      hit_pulse <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b0;
      dead      <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (restart) begin
        // Restart wins over a coincident tick; that frame's damage is dropped.
        r_state   <= ST_ALIVE;
        r_l1      <= 1'b0;
        r_l2      <= 1'b0;
        r_inv_cnt <= 8'd0;
        hp        <= HP_MAX_8;
        bar_x_end <= BAR_X0_10 + {2'b00, HP_MAX_8};
        invuln    <= 1'b0;
        blink     <= 1'b0;
        dead      <= 1'b0;
      end else begin
        case (r_state)
          ST_ALIVE: begin
            if (frame_tick) begin
              r_l1 <= 1'b0;
              r_l2 <= 1'b0;
              if (w_dmg != 9'd0) begin
                hit_pulse <= 1'b1;
                if (w_dmg >= {1'b0, hp}) begin
                  r_state   <= ST_DEAD;
                  hp        <= 8'd0;
                  bar_x_end <= BAR_X0_10;
                  dead      <= 1'b1;
                end else begin
                  r_state   <= ST_INVULN;
                  hp        <= w_hp_left;
                  bar_x_end <= BAR_X0_10 + {2'b00, w_hp_left};
                  r_inv_cnt <= INV_8;
                  invuln    <= 1'b1;
                  blink     <= INV_8[2];
                end
              end
            end else begin
              r_l1 <= r_l1 | isCollisionB1;
              r_l2 <= r_l2 | isCollisionB2;
            end
          end
          ST_INVULN: begin
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
            if (frame_tick) begin
              // A count of 0 is treated like 1 so a corrupted counter cannot
              // trap the player in a 255-frame window.
              if (r_inv_cnt <= 8'd1) begin
                r_state   <= ST_ALIVE;
                r_inv_cnt <= 8'd0;
                invuln    <= 1'b0;
                blink     <= 1'b0;
              end else begin
                r_inv_cnt <= w_cnt_dec;
                blink     <= w_cnt_dec[2];
              end
            end
          end
          ST_DEAD: begin
            r_l1      <= 1'b0;
            r_l2      <= 1'b0;
            hp        <= 8'd0;
            bar_x_end <= BAR_X0_10;
            invuln    <= 1'b0;
            blink     <= 1'b0;
            dead      <= 1'b1;
          end
          default: begin
            r_state   <= ST_ALIVE;
            r_l1      <= 1'b0;
            r_l2      <= 1'b0;
            r_inv_cnt <= 8'd0;
            invuln    <= 1'b0;
            blink     <= 1'b0;
            dead      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hp_damage_ctrl.md
# hp_damage_ctrl

Frame-synchronous damage sequencer for the player's HP. It collects the per-pixel bullet collision levels (isCollisionB1, isCollisionB2) over a video frame and applies one combined damage event per frame at the frame tick. It enforces an invulnerability window after each hit and saturates HP at zero. It drives the HP value and bar end coordinate consumed by the HP bar renderer, plus dead/blink flags for the game FSM and the player sprite.

## Interface
- HP_MAX, 150: starting and restart HP, 1..255.
- DMG_B1, 30: damage per frame for bullet group 1.
- DMG_B2, 30: damage per frame for bullet group 2.
- INV_FRAMES, 60: invulnerability length in frames, 1..255.
- BAR_X0, 50: left x pixel of the HP bar.

- Pclk  input  1  25 MHz pixel clock. All logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per frame, issued at the end of active video.
- isCollisionB1  input  1  level; high on pixels where the player overlaps group-1 bullets.
- isCollisionB2  input  1  level; same for group 2.
- restart  input  1  one-cycle pulse that requests a new game.
- hp  output  8  current HP, 0..HP_MAX.
- bar_x_end  output  10  BAR_X0 + hp; the renderer draws xx > BAR_X0 && xx < bar_x_end.
- hit_pulse  output  1  one-cycle pulse when damage is applied.
- invuln  output  1  high during the invulnerability window.
- blink  output  1  sprite flash; equals inv_cnt[2] while invuln, otherwise 0.
- dead  output  1  high in state DEAD.

## Operation
- States are ALIVE, INVULN and DEAD. Reset state is ALIVE.
- Reset values: hp = HP_MAX, bar_x_end = BAR_X0 + HP_MAX, hit_pulse = 0, invuln = 0, blink = 0, dead = 0. Latches and inv_cnt are also cleared.
- Collision latches l1 and l2:
  - Each is set by its collision input in ALIVE.
  - Both are held at 0 in INVULN and DEAD.
  - Both are cleared on every frame_tick.
- The evaluation term is e1 = l1 | isCollisionB1, and likewise e2. A collision in the frame_tick cycle therefore counts toward the ending frame.
- ALIVE, on frame_tick:
  - dmg = (e1 ? DMG_B1 : 0) + (e2 ? DMG_B2 : 0), computed 9 bits wide.
  - If dmg = 0, nothing happens.
  - If dmg >= hp: hp <= 0, hit_pulse, go to DEAD.
  - Otherwise: hp <= hp - dmg, hit_pulse, inv_cnt <= INV_FRAMES, go to INVULN.
- INVULN, on frame_tick:
  - inv_cnt decrements.
  - When inv_cnt reaches 1 before the decrement, go to ALIVE.
  - Collisions are ignored for the whole window, including the tick that returns to ALIVE. Damage resumes with the next full frame.
- DEAD: hp holds at 0 and collisions are ignored. Only restart exits.
- restart, in any state:
  - hp <= HP_MAX, latches cleared, inv_cnt <= 0, go to ALIVE.
  - restart has priority over a coincident frame_tick; that tick's damage is discarded.
- Simultaneous B1 and B2 in one frame produce a single hit_pulse with the summed damage.
- hp never underflows and never exceeds HP_MAX. bar_x_end is registered and updates together with hp.

## Timing
- A collision level on cycle n sets its latch at edge n+1.
- hp, bar_x_end, state and dead update on the edge that samples frame_tick. They are therefore valid in the cycle after the tick.
- hit_pulse is high for exactly that one following cycle.
- invuln rises with the state change and falls on the edge after the last INVULN tick.
- Restart takes effect one edge after it is sampled.
- Asserting rst_n low mid-frame forces all reset values immediately, independent of Pclk. Release is synchronous to the next rising edge; a standard reset synchronizer sits outside this block.
- No combinational path exists from any input to any output.

## Test plan
- Reset, then B1 high for 20 pixels in one frame, then tick: hp 150 -> 120, bar_x_end 200 -> 170, hit_pulse for 1 cycle, invuln = 1.
- B1 and B2 both in one frame: hp 150 -> 90 with a single hit_pulse. Collisions during the next 60 ticks leave hp at 90; the collision on the 61st frame gives hp = 60.
- Collision asserted only in the frame_tick cycle: damage is applied (hp 150 -> 120).
- hp = 30 and both groups hit: hp = 0 (saturated, no wrap), dead = 1. Further collisions and ticks leave hp = 0.
- restart together with a frame_tick and a collision: hp = 150, state ALIVE, no hit_pulse. Also from DEAD: dead falls the cycle after restart.
- rst_n pulsed low mid-INVULN with hp = 90: outputs return to reset values asynchronously, hp = 150, invuln = 0.
- During INVULN, blink toggles every 4 ticks.
